game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Game supervisor directly upstream of the button/score stage.
- Generates the shared 2-bit game state (IDLE/RUN/END/PAUSE) from start and pause buttons.
- Generates the one-cycle LED-change tick LCT that tells the score stage to reload LEDs from the PRBS.
- Runs the game countdown timer and reports remaining seconds and end of game.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per game second (range 2..2^32-1).
- GAME_SECONDS, 30, game length in seconds (range 1..255).
- LCT_PERIOD, 25_000_000, clk cycles between LCT pulses in RUN (range 2..TICK_DIV*GAME_SECONDS).
- LCT_MIN, 5_000_000, floor on LCT period (used only with SPEEDUP_EN).
- LCT_STEP, 2_500_000, period decrement per speed-up step (used only with SPEEDUP_EN).
- SPEEDUP_SECS, 10, seconds between speed-up steps (used only with SPEEDUP_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_btn  in  1  start button level; already synchronous and debounced.
- pause_btn  in  1  pause button level; already synchronous and debounced.
- STATE  out  2  game state: 00 IDLE, 01 RUN, 10 END, 11 PAUSE.
- LCT  out  1  LED-change tick; one-cycle pulse.
- time_left  out  8  remaining seconds, binary.
- game_over  out  1  one-cycle pulse on the RUN->END transition.

Behaviour:
- All outputs are registered.
- Reset (asserts asynchronously; counters held while rst_n low):
  - STATE=00, LCT=0, time_left=GAME_SECONDS, game_over=0.
  - Second prescaler, LCT counter and edge-detect registers cleared.
  - Sampling restarts on the first rising clk edge after rst_n rises.
- Edge detect: a press is cur & ~prev on each button. Only rising edges act; held levels are ignored.
- IDLE (00):
  - start press -> RUN. On the same edge: time_left=GAME_SECONDS, prescaler=0, LCT counter=0.
  - LCT=1 in the first RUN cycle so LEDs light immediately.
  - pause is ignored in IDLE.
- RUN (01):
  - Prescaler counts 0..TICK_DIV-1. On wrap, time_left decrements by 1.
  - Wrap while time_left==1 -> time_left=0, STATE=END, game_over=1 for one cycle.
  - LCT counter counts 0..P-1, where P is the current period. On wrap, LCT=1 for one cycle; otherwise LCT=0.
  - pause press -> PAUSE. start is ignored in RUN.
- PAUSE (11):
  - Prescaler, LCT counter and time_left are frozen; LCT=0.
  - pause press -> RUN, resuming from the frozen counts. No extra LCT on resume.
  - start is ignored in PAUSE.
- END (10):
  - time_left held at 0; LCT=0.
  - start press -> IDLE, allowing the score stage to clear. A second start press is required to begin a new game.
- Simultaneous events:
  - IDLE, start and pause pressed together: start wins.
  - RUN, expiry and pause press in the same cycle: expiry wins (-> END).
  - LCT wrap coinciding with expiry: LCT suppressed.
  - LCT wrap coinciding with a second tick (not expiry): both take effect.
- LCT is never high in IDLE, END or PAUSE.
- game_over is never high outside the RUN->END edge.
- Reset mid-game returns to IDLE immediately with the reset values above.
- Widths: counters sized by $clog2 of their parameter. No counter ever exceeds its terminal value.

Optional Feature:
- Macro: GAME_CTRL_SPEEDUP_EN.
- Defined:
  - Current LCT period P starts at LCT_PERIOD on each start.
  - Every SPEEDUP_SECS elapsed RUN seconds, P = max(P-LCT_STEP, LCT_MIN). The new P takes effect at the next LCT counter wrap.
  - P is frozen in PAUSE and reloaded on entry to RUN from IDLE.
- Undefined: P is constantly LCT_PERIOD; no speed-up logic is synthesised.

Test Plan (TICK_DIV=10, GAME_SECONDS=3, LCT_PERIOD=4, macro off unless stated):
1. Reset then start pulse -> STATE=01 next edge; LCT=1 first RUN cycle; LCT again every 4 cycles; time_left 3,2,1 at 10-cycle intervals.
2. Run 30 cycles -> time_left=0, STATE=10, game_over high exactly 1 cycle, LCT=0 thereafter; start -> STATE=00, time_left=3.
3. Pause at RUN cycle 13 for 20 cycles -> STATE=11, no LCT, time_left frozen at 2; pause again -> RUN, expiry occurs 17 RUN cycles later.
4. start held high for 50 cycles from IDLE -> exactly one transition to RUN; start and pause pressed together in IDLE -> RUN.
5. rst_n pulled low mid-RUN (time_left=2) -> STATE=00, LCT=0, time_left=3 immediately, without waiting for a clock edge.
6. With GAME_CTRL_SPEEDUP_EN, LCT_PERIOD=8, LCT_STEP=2, LCT_MIN=4, SPEEDUP_SECS=1, GAME_SECONDS=5 -> LCT spacing 8, then 6, then 4, then stays 4.

Source files
------------

// File: rtl/game_ctrl.sv
// Game supervisor: start/pause FSM, countdown timer, game_over pulse and LED-change tick (LCT).
// Optional LCT speed-up is built only when GAME_CTRL_SPEEDUP_EN is defined.
module game_ctrl #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned GAME_SECONDS = 30,
  parameter int unsigned LCT_PERIOD   = 25_000_000,
  parameter int unsigned LCT_MIN      = 5_000_000,
  parameter int unsigned LCT_STEP     = 2_500_000,
  parameter int unsigned SPEEDUP_SECS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       pause_btn,
  output logic [1:0] STATE,
  output logic       LCT,
  output logic [7:0] time_left,
  output logic       game_over
);

  localparam int unsigned   PW        = $clog2(TICK_DIV);
  localparam int unsigned   LW        = $clog2(LCT_PERIOD);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LCT_MAX   = LW'(LCT_PERIOD - 1);
  localparam logic [7:0]    SECS_INIT = 8'(GAME_SECONDS);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StEnd   = 2'b10,
    StPause = 2'b11
  } state_e;

  state_e          r_state;
  logic [PW-1:0]   r_presc;
  logic [LW-1:0]   r_lct_cnt;
  logic [7:0]      r_time_left;
  logic            r_lct;
  logic            r_game_over;
  logic            r_start_prev;
  logic            r_pause_prev;

  logic            w_start_press;
  logic            w_pause_press;
  logic            w_presc_wrap;
  logic            w_lct_wrap;
  logic            w_expire;
  logic            w_run_adv;
  logic            w_start_go;
  logic [LW-1:0]   w_lct_max;

  assign w_start_press = start_btn & ~r_start_prev;
  assign w_pause_press = pause_btn & ~r_pause_prev;
  assign w_presc_wrap  = (r_presc == PRESC_MAX);
  assign w_lct_wrap    = (r_lct_cnt == w_lct_max);
  assign w_expire      = (r_state == StRun) & w_presc_wrap & (r_time_left == 8'd1);
  // Counters advance only in RUN cycles that neither expire nor pause; the pausing
  // cycle itself is frozen so no LCT can land in the first PAUSE cycle.
  assign w_run_adv     = (r_state == StRun) & ~w_expire & ~w_pause_press;
  assign w_start_go    = (r_state == StIdle) & w_start_press;

`ifdef GAME_CTRL_SPEEDUP_EN
  localparam int unsigned   SW       = (SPEEDUP_SECS > 1) ? $clog2(SPEEDUP_SECS) : 1;
  localparam logic [SW-1:0] SEC_MAX  = SW'(SPEEDUP_SECS - 1);
  localparam logic [LW-1:0] MIN_M1   = LW'(LCT_MIN - 1);
  localparam logic [LW-1:0] STEP_V   = LW'(LCT_STEP);

  logic [SW-1:0] r_sec;
  logic [LW-1:0] r_period_m1;
  logic [LW-1:0] r_pend_m1;
  logic [LW-1:0] w_pend_next;

  // Periods are held as (P-1); floor at LCT_MIN without underflowing.
  assign w_pend_next = (32'(r_pend_m1) >= LCT_MIN + LCT_STEP - 1) ? r_pend_m1 - STEP_V : MIN_M1;
  assign w_lct_max   = r_period_m1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec       <= '0;
      r_period_m1 <= LCT_MAX;
      r_pend_m1   <= LCT_MAX;
    end else if (w_start_go) begin
      r_sec       <= '0;
      r_period_m1 <= LCT_MAX;
      r_pend_m1   <= LCT_MAX;
    end else if (w_run_adv) begin
      if (w_presc_wrap) begin
        if (r_sec == SEC_MAX) begin
          r_sec     <= '0;
          r_pend_m1 <= w_pend_next;
        end else begin
          r_sec <= r_sec + 1'b1;
        end
      end
      // A step landing on the same edge as a wrap applies at the following wrap.
      if (w_lct_wrap) r_period_m1 <= r_pend_m1;
    end
  end
`else
  logic w_unused_params;
  assign w_unused_params = ^{LCT_MIN, LCT_STEP, SPEEDUP_SECS};
  assign w_lct_max       = LCT_MAX;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_presc      <= '0;
      r_lct_cnt    <= '0;
      r_time_left  <= SECS_INIT;
      r_lct        <= 1'b0;
      r_game_over  <= 1'b0;
      r_start_prev <= 1'b0;
      r_pause_prev <= 1'b0;
    end else begin
      r_start_prev <= start_btn;
      r_pause_prev <= pause_btn;
      r_lct        <= 1'b0;
      r_game_over  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_start_press) begin
            r_state     <= StRun;
            r_time_left <= SECS_INIT;
            r_presc     <= '0;
            r_lct_cnt   <= '0;
            r_lct       <= 1'b1;
          end
        end
        StRun: begin
          if (w_expire) begin
            r_state     <= StEnd;
            r_time_left <= '0;
            r_game_over <= 1'b1;
          end else if (w_pause_press) begin
            r_state <= StPause;
          end else begin
            if (w_presc_wrap) begin
              r_presc     <= '0;
              r_time_left <= r_time_left - 8'd1;
            end else begin
              r_presc <= r_presc + 1'b1;
            end
            if (w_lct_wrap) begin
              r_lct_cnt <= '0;
              r_lct     <= 1'b1;
            end else begin
              r_lct_cnt <= r_lct_cnt + 1'b1;
            end
          end
        end
        StPause: begin
          if (w_pause_press) r_state <= StRun;
        end
        StEnd: begin
          r_time_left <= '0;
          if (w_start_press) begin
            r_state     <= StIdle;
            r_time_left <= SECS_INIT;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign STATE     = r_state;
  assign LCT       = r_lct;
  assign time_left = r_time_left;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with TICK_DIV=10; speed-up scenario runs when
// GAME_CTRL_SPEEDUP_EN is defined, otherwise the base game scenarios run.
module tb_game_ctrl;

`ifdef GAME_CTRL_SPEEDUP_EN
  localparam int unsigned GS = 5;
  localparam int unsigned LP = 8;
`else
  localparam int unsigned GS = 3;
  localparam int unsigned LP = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic [1:0] state;
  logic       lct;
  logic [7:0] time_left;
  logic       game_over;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  game_ctrl #(
    .TICK_DIV    (10),
    .GAME_SECONDS(GS),
    .LCT_PERIOD  (LP),
    .LCT_MIN     (4),
    .LCT_STEP    (2),
    .SPEEDUP_SECS(1)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_btn(start_btn),
    .pause_btn(pause_btn),
    .STATE    (state),
    .LCT      (lct),
    .time_left(time_left),
    .game_over(game_over)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #4;
    n_checks++;
    if ({state, lct, game_over, time_left} !== {2'b00, 1'b0, 1'b0, 8'(GS)})
      $display("FAIL reset_vals got %h want %h", {state, lct, game_over, time_left},
               {2'b00, 1'b0, 1'b0, 8'(GS)});
    else n_pass++;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if (state !== 2'b00) $display("FAIL reset_idle got %b want 00", state);
    else n_pass++;
  endtask

`ifdef GAME_CTRL_SPEEDUP_EN
  task automatic test_speedup();
    logic e_lct;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    n_checks++;
    if ({state, lct} !== 3'b011) $display("FAIL sp_first got %b want 011", {state, lct});
    else n_pass++;
    // Expected gaps 8,8,6,4,4,...; the wrap at cycle 50 coincides with expiry.
    for (int k = 1; k < 50; k++) begin
      step();
      e_lct = (k inside {8, 16, 22, 26, 30, 34, 38, 42, 46});
      n_checks++;
      if ({state, lct} !== {2'b01, e_lct})
        $display("FAIL sp_lct cyc %0d got %b want %b", k, {state, lct}, {2'b01, e_lct});
      else n_pass++;
    end
    step();
    n_checks++;
    if ({state, lct, game_over} !== 4'b1001)
      $display("FAIL sp_expire got %b want 1001", {state, lct, game_over});
    else n_pass++;
  endtask
`else
  task automatic test_start();
    logic       e_lct;
    logic [7:0] e_tl;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    n_checks++;
    if ({state, lct, time_left} !== {2'b01, 1'b1, 8'd3})
      $display("FAIL start_first got %h want %h", {state, lct, time_left}, {2'b01, 1'b1, 8'd3});
    else n_pass++;
    for (int k = 1; k < 30; k++) begin
      if (k == 15) start_btn = 1'b1;
      if (k == 17) start_btn = 1'b0;
      step();
      e_lct = (k % 4 == 0);
      e_tl  = 8'(3 - k / 10);
      n_checks++;
      if ({state, lct, time_left} !== {2'b01, e_lct, e_tl})
        $display("FAIL run_cyc %0d got %h want %h", k, {state, lct, time_left},
                 {2'b01, e_lct, e_tl});
      else n_pass++;
    end
  endtask

  task automatic test_expiry();
    step();
    n_checks++;
    if ({state, lct, game_over, time_left} !== {2'b10, 1'b0, 1'b1, 8'd0})
      $display("FAIL expire got %h want %h", {state, lct, game_over, time_left},
               {2'b10, 1'b0, 1'b1, 8'd0});
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({state, lct, game_over, time_left} !== {2'b10, 1'b0, 1'b0, 8'd0})
        $display("FAIL end_hold %0d got %h want %h", i, {state, lct, game_over, time_left},
                 {2'b10, 1'b0, 1'b0, 8'd0});
      else n_pass++;
    end
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    n_checks++;
    if ({state, time_left} !== {2'b00, 8'd3})
      $display("FAIL end_to_idle got %h want %h", {state, time_left}, {2'b00, 8'd3});
    else n_pass++;
    repeat (3) step();
    n_checks++;
    if (state !== 2'b00) $display("FAIL idle_wait got %b want 00", state);
    else n_pass++;
  endtask

  task automatic test_pause();
    logic       e_lct;
    logic [7:0] e_tl;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    repeat (13) step();
    n_checks++;
    if ({state, lct, time_left} !== {2'b01, 1'b0, 8'd2})
      $display("FAIL pre_pause got %h want %h", {state, lct, time_left}, {2'b01, 1'b0, 8'd2});
    else n_pass++;
    pause_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) start_btn = 1'b1;
      if (i == 6) start_btn = 1'b0;
      step();
      n_checks++;
      if ({state, lct, time_left} !== {2'b11, 1'b0, 8'd2})
        $display("FAIL paused %0d got %h want %h", i, {state, lct, time_left},
                 {2'b11, 1'b0, 8'd2});
      else n_pass++;
    end
    pause_btn = 1'b0;
    step();
    pause_btn = 1'b1;
    step();
    pause_btn = 1'b0;
    n_checks++;
    if ({state, lct, time_left} !== {2'b01, 1'b0, 8'd2})
      $display("FAIL resume got %h want %h", {state, lct, time_left}, {2'b01, 1'b0, 8'd2});
    else n_pass++;
    // Frozen counts: prescaler 3, LCT counter 1.
    for (int r = 2; r <= 17; r++) begin
      step();
      e_lct = (r >= 4) && ((r - 4) % 4 == 0);
      e_tl  = (r >= 8) ? 8'd1 : 8'd2;
      n_checks++;
      if ({state, lct, time_left} !== {2'b01, e_lct, e_tl})
        $display("FAIL resumed %0d got %h want %h", r, {state, lct, time_left},
                 {2'b01, e_lct, e_tl});
      else n_pass++;
      if (r == 17) pause_btn = 1'b1;
    end
    step();
    pause_btn = 1'b0;
    n_checks++;
    if ({state, game_over, time_left} !== {2'b10, 1'b1, 8'd0})
      $display("FAIL expire_vs_pause got %h want %h", {state, game_over, time_left},
               {2'b10, 1'b1, 8'd0});
    else n_pass++;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
  endtask

  task automatic test_held_start();
    int         n_runs;
    logic [1:0] prev;
    n_runs    = 0;
    prev      = state;
    start_btn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (prev == 2'b00 && state == 2'b01) n_runs++;
      prev = state;
    end
    n_checks++;
    if (n_runs !== 1) $display("FAIL held_runs got %0d want 1", n_runs);
    else n_pass++;
    n_checks++;
    if ({state, time_left} !== {2'b10, 8'd0})
      $display("FAIL held_end got %h want %h", {state, time_left}, {2'b10, 8'd0});
    else n_pass++;
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    pause_btn = 1'b1;
    step();
    start_btn = 1'b0;
    pause_btn = 1'b0;
    n_checks++;
    if ({state, lct} !== 3'b011) $display("FAIL start_and_pause got %b want 011", {state, lct});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    repeat (12) step();
    n_checks++;
    if ({state, lct, time_left} !== {2'b01, 1'b1, 8'd2})
      $display("FAIL pre_reset got %h want %h", {state, lct, time_left}, {2'b01, 1'b1, 8'd2});
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({state, lct, game_over, time_left} !== {2'b00, 1'b0, 1'b0, 8'd3})
      $display("FAIL async_reset got %h want %h", {state, lct, game_over, time_left},
               {2'b00, 1'b0, 1'b0, 8'd3});
    else n_pass++;
    step();
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if ({state, time_left} !== {2'b00, 8'd3})
      $display("FAIL post_reset got %h want %h", {state, time_left}, {2'b00, 8'd3});
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef GAME_CTRL_SPEEDUP_EN
    test_speedup();
`else
    test_start();
    test_expiry();
    test_pause();
    test_held_start();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
